instr_sequencer: RTL

//  Multi-cycle control unit upstream of the 8x8 register file and function unit.

---
 rtl/instr_sequencer_pkg.sv | 55 +++++
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/instr_sequencer_decode.sv | 55 +++++
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the instruction sequencer and the function unit it
//   steers: opcode values, function-select encodings, sequencer FSM states and
//   the decoded-control bundle produced by instr_decode.
//   The FS_* values are the function unit's own select codes. Change them only
//   together with the function unit.
// -----------------------------------------------------------------------------
package ctrl_pkg;

   // Opcodes, instr[15:12]. 0xC-0xE are undefined.
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_MOV  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_ADDI = 4'h9;
   localparam logic [3:0] OP_BRZ  = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Function-unit select codes
   localparam logic [3:0] FS_ADD   = 4'd0;
   localparam logic [3:0] FS_SUB   = 4'd1;
   localparam logic [3:0] FS_AND   = 4'd2;
   localparam logic [3:0] FS_OR    = 4'd3;
   localparam logic [3:0] FS_XOR   = 4'd4;
   localparam logic [3:0] FS_NOT   = 4'd5;
   localparam logic [3:0] FS_PASSA = 4'd6;
   localparam logic [3:0] FS_PASSB = 4'd7;

   // Sequencer states
   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } state_t;

   // Decoded control for the instruction held in IR
   typedef struct packed {
      logic [3:0] fs;
      logic       imm_sel;
      logic       wr_en;
      logic       is_brz;
      logic       is_jmp;
      logic       is_halt;
      logic       is_illegal;
   } dec_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
//   Instruction fetch port between the instruction source and the sequencer.
//   Ports / signals:
//     instr_valid  source -> seq  source holds a valid instruction word
//     instr        source -> seq  16-bit instruction word
//     instr_ready  seq -> source  sequencer accepts the word this cycle
//     pc           seq -> source  address of the next instruction to fetch
//   A word is transferred on a rising edge where instr_valid && instr_ready.
//   master: instruction source side.  slave: sequencer side.
// -----------------------------------------------------------------------------
interface instr_sequencer_if #(
   parameter int PC_W = 8
);
   logic            instr_valid;
   logic            instr_ready;
   logic [15:0]     instr;
   logic [PC_W-1:0] pc;

   modport master (
      output instr_valid,
      output instr,
      input  instr_ready,
      input  pc
   );

   modport slave (
      input  instr_valid,
      input  instr,
      output instr_ready,
      output pc
   );
endinterface

// File: rtl/instr_sequencer_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//   Purely combinational decode of the instruction register.
//   Ports:
//     ir   in   16      instruction register
//     ctl  out  dec_t   fs, imm_sel, wr_en, is_brz, is_jmp, is_halt, is_illegal
//     imm  out  DATA_W  immediate operand (LDI: imm8, ADDI: imm3 zero-extended)
//   Ops that do not use the function unit (NOP, JMP, HALT, illegal) leave fs
//   at FS_ADD (code 0) with no write, so nothing they select is ever stored.
// -----------------------------------------------------------------------------
module instr_decode
   import ctrl_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [15:0]       ir,
   output dec_t              ctl,
   output logic [DATA_W-1:0] imm
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default before the
      // case; a path that skips an assignment would otherwise infer a latch.
      ctl = '0;
      imm = '0;
      case (ir[15:12])
         OP_NOP:  ;
         OP_ADD:  begin ctl.fs = FS_ADD;   ctl.wr_en = 1'b1; end
         OP_SUB:  begin ctl.fs = FS_SUB;   ctl.wr_en = 1'b1; end
         OP_AND:  begin ctl.fs = FS_AND;   ctl.wr_en = 1'b1; end
         OP_OR:   begin ctl.fs = FS_OR;    ctl.wr_en = 1'b1; end
         OP_XOR:  begin ctl.fs = FS_XOR;   ctl.wr_en = 1'b1; end
         OP_NOT:  begin ctl.fs = FS_NOT;   ctl.wr_en = 1'b1; end
         OP_MOV:  begin ctl.fs = FS_PASSA; ctl.wr_en = 1'b1; end
         OP_LDI: begin
            ctl.fs      = FS_PASSB;
            ctl.imm_sel = 1'b1;
            ctl.wr_en   = 1'b1;
            imm         = DATA_W'(ir[7:0]);
         end
         OP_ADDI: begin
            ctl.fs      = FS_ADD;
            ctl.imm_sel = 1'b1;
            ctl.wr_en   = 1'b1;
            imm         = DATA_W'(ir[5:3]);
         end
         // BRZ routes reg[sa] through the function unit so that zero reflects it
         OP_BRZ:  begin ctl.fs = FS_PASSA; ctl.is_brz = 1'b1; end
         OP_JMP:  ctl.is_jmp  = 1'b1;
         OP_HALT: ctl.is_halt = 1'b1;
         default: ctl.is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control unit for the 8x8 register file and function unit.
//   Fetches one instruction per FETCH -> DECODE -> EXEC round (3 cycles),
//   keeps the PC, drives register-file addresses and function-unit controls,
//   and resolves BRZ/JMP using the function unit's zero flag.
//   Ports:
//     clk      in   1       clock, rising edge
//     reset    in   1       synchronous, active-high
//     fetch    slave        instruction fetch port (instr_valid/instr/
//                           instr_ready/pc)
//     zero     in   1       function-unit result == 0 (combinational)
//     da/aa/ba out  3 each  register-file dest / A / B addresses
//     rw       out  1       register-file write enable (EXEC of ops 1-9)
//     fs       out  4       function select
//     imm_sel  out  1       1: B operand = imm, 0: B operand = reg[ba]
//     imm      out  DATA_W  immediate operand
//     halted   out  1       HALT has executed
//     illegal  out  1       one-cycle pulse in EXEC of an undefined opcode
// -----------------------------------------------------------------------------
module instr_sequencer
   import ctrl_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   instr_sequencer_if.slave  fetch,
   input  logic              zero,
   output logic [2:0]        da,
   output logic [2:0]        aa,
   output logic [2:0]        ba,
   output logic              rw,
   output logic [3:0]        fs,
   output logic              imm_sel,
   output logic [DATA_W-1:0] imm,
   output logic              halted,
   output logic              illegal
);

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   state_t            state;
   state_t            state_nx;
   logic [15:0]       ir;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_nx;
   logic [PC_W-1:0]   br_off;
   logic              in_fetch;
   logic              in_exec;
   logic              active;
   logic              accept;
   dec_t              dec;
   logic [DATA_W-1:0] dec_imm;

   instr_decode #(
      .DATA_W (DATA_W)
   ) u_decode (
      .ir  (ir),
      .ctl (dec),
      .imm (dec_imm)
   );

   // Branch offset off8 sign-extended to the PC width; the sum wraps
   // modulo 2^PC_W with no overflow indication.
   assign br_off = PC_W'($signed(ir[7:0]));

   assign in_fetch = (state == FETCH);
   assign in_exec  = (state == EXEC);
   assign active   = (state == DECODE) || in_exec;

   // Handshake is blocked during reset so the reset edge never loads IR
   // with a source word.
   assign accept = in_fetch && fetch.instr_valid && !reset;

   // ---------------------------------------------------------------------------
   // State, PC and IR registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state <= FETCH;
         pc_q  <= '0;
         ir    <= '0;
      end else begin
         state <= state_nx;
         pc_q  <= pc_nx;
         if (accept) begin
            ir <= fetch.instr;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and next PC
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      pc_nx    = pc_q;
      case (state)
         FETCH: begin
            if (fetch.instr_valid) begin
               state_nx = DECODE;
               pc_nx    = pc_q + PC_ONE;
            end
         end
         DECODE: state_nx = EXEC;
         EXEC: begin
            state_nx = dec.is_halt ? HALTED : FETCH;
            // pc already points past this instruction, so the offset is
            // relative to the incremented PC.
            if (dec.is_jmp || (dec.is_brz && zero)) begin
               pc_nx = pc_q + br_off;
            end
         end
         HALTED: ;
         default: state_nx = FETCH;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Datapath controls are driven from IR only in DECODE and EXEC so the
   // register file and function unit see a quiet, all-zero bus while the
   // sequencer idles in FETCH or HALTED. Every strobe is also forced low
   // while reset is high: reset is synchronous, so without this gate a
   // write or accept could still happen on the reset edge itself.
   always_comb begin
      da      = '0;
      aa      = '0;
      ba      = '0;
      fs      = '0;
      imm_sel = 1'b0;
      imm     = '0;
      if (active && !reset) begin
         da      = ir[11:9];
         aa      = ir[8:6];
         ba      = ir[5:3];
         fs      = dec.fs;
         imm_sel = dec.imm_sel;
         imm     = dec_imm;
      end
   end

   // The write lands on the EXEC -> FETCH edge
   assign rw                = in_exec && dec.wr_en && !reset;
   assign illegal           = in_exec && dec.is_illegal && !reset;
   assign halted            = (state == HALTED) && !reset;
   assign fetch.instr_ready = in_fetch && !reset;
   assign fetch.pc          = pc_q;

endmodule
